if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 32-bit 5-stage MIPS pipeline, directly upstream of the instruction memory.
- Owns the PC and drives the instruction memory address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, redirect (branch/jump) with bubble insertion, boot sequencing, out-of-range halt and misaligned-target detection.

---
 rtl/mips_pkg.sv | 11 +
 rtl/if_id_reg.sv | 20 ++
 rtl/if_fetch_unit.sv | 79 +++++++
 tb/tb_if_fetch_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared pipeline types and constants for the MIPS core
package mips_pkg;
    localparam int WORD_BYTES = 4;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with hold and synchronous clear-to-bubble
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hold,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);
    localparam if_id_t BUBBLE = '{instr: NOP_INSTR, pc4: 32'd0, valid: 1'b0};
    // flush beats hold so a redirect can squash a stalled slot
    always_ff @(posedge clk) begin
        if (reset || flush) q <= BUBBLE;
        else if (!hold) q <= d;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, boot/run/halt FSM and IF/ID register (optional IF_PERF_COUNTERS_EN adds fetch/bubble counters)
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter logic [31:0] NOP_INSTR  = DEFAULT_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted,
`ifdef IF_PERF_COUNTERS_EN
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count,
`endif
    output logic        misalign
);
    localparam logic [31:0] PC_LIMIT = 32'(WORD_BYTES * IMEM_DEPTH);
    fetch_state_t state;
    logic [31:0] pc, pc_plus4, pc_next;
    logic in_run, take_redirect, go_halt, capture;
    if_id_t id_d, id_q;
    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'(WORD_BYTES);
    // decode the RUN priority: redirect, then stall, then range check, then capture
    always_comb begin
        in_run        = state == RUN;
        take_redirect = in_run && redirect;
        go_halt       = in_run && !redirect && !stall && pc >= PC_LIMIT;
        capture       = in_run && !redirect && !stall && pc < PC_LIMIT;
        pc_next       = take_redirect ? {redirect_target[31:2], 2'b00} : capture ? pc_plus4 : pc;
        id_d          = '{instr: imem_instr, pc4: pc_plus4, valid: 1'b1};
    end
    // PC, FSM and status flags; halt is sticky until reset
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            state    <= BOOT;
            halted   <= 1'b0;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_next;
            state    <= state == BOOT ? RUN : go_halt ? HALT : state;
            halted   <= halted || go_halt;
            misalign <= take_redirect && |redirect_target[1:0];
        end
    end
    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk  (clk),
        .reset(reset),
        .hold (!capture),
        .flush(take_redirect || go_halt),
        .d    (id_d),
        .q    (id_q)
    );
    assign if_id_instr = id_q.instr;
    assign if_id_pc4   = id_q.pc4;
    assign if_id_valid = id_q.valid;
`ifdef IF_PERF_COUNTERS_EN
    // saturating counters of useful fetches and lost RUN cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else begin
            if (capture && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
            if (in_run && (stall || redirect) && bubble_count != 32'hFFFF_FFFF) bubble_count <= bubble_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for the fetch stage
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] imem_addr, imem_instr, if_id_instr, if_id_pc4;
    logic        if_id_valid, halted, misalign;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetch_count, bubble_count;
`endif
    logic [31:0] mem [1024];
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd4096) ? mem[imem_addr[11:2]] : 32'hFFFF_FFFF;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .halted(halted),
`ifdef IF_PERF_COUNTERS_EN
        .fetch_count(fetch_count), .bubble_count(bubble_count),
`endif
        .misalign(misalign)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_instr"}, if_id_instr, 32'h0);
        check({tag, "_pc4"}, if_id_pc4, 32'h0);
        check({tag, "_valid"}, 32'(if_id_valid), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_misalign"}, 32'(misalign), 32'h0);
        check({tag, "_addr"}, imem_addr, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1234_0000 | 32'(i);
        // reset state
        step();
        check_reset_values("rst");
`ifdef IF_PERF_COUNTERS_EN
        check("rst_fetch_cnt", fetch_count, 32'h0);
`endif
        // boot cycle then sequential fetch A,B
        reset = 1'b0;
        step();
        check("boot_valid", 32'(if_id_valid), 32'h0);
        check("boot_addr", imem_addr, 32'h0);
        step();
        check("A_instr", if_id_instr, 32'h1234_0000);
        check("A_pc4", if_id_pc4, 32'h4);
        check("A_valid", 32'(if_id_valid), 32'h1);
        step();
        check("B_instr", if_id_instr, 32'h1234_0001);
        check("B_pc4", if_id_pc4, 32'h8);
        check("B_addr", imem_addr, 32'h8);
        // three-cycle stall holding B
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_instr", if_id_instr, 32'h1234_0001);
            check("stall_addr", imem_addr, 32'h8);
        end
        stall = 1'b0;
        step();
        check("C_instr", if_id_instr, 32'h1234_0002);
        check("C_pc4", if_id_pc4, 32'hC);
        step();
        check("D_instr", if_id_instr, 32'h1234_0003);
        check("D_pc4", if_id_pc4, 32'h10);
        // redirect beats simultaneous stall
        redirect = 1'b1;
        redirect_target = 32'h40;
        stall = 1'b1;
        step();
        check("redir_addr", imem_addr, 32'h40);
        check("redir_instr", if_id_instr, 32'h0);
        check("redir_valid", 32'(if_id_valid), 32'h0);
        check("redir_misalign", 32'(misalign), 32'h0);
        redirect = 1'b0;
        stall = 1'b0;
        step();
        check("w16_instr", if_id_instr, 32'h1234_0010);
        check("w16_pc4", if_id_pc4, 32'h44);
        check("w16_valid", 32'(if_id_valid), 32'h1);
        // misaligned target: one-cycle pulse, target aligned down
        redirect = 1'b1;
        redirect_target = 32'h42;
        step();
        check("mis_pulse", 32'(misalign), 32'h1);
        check("mis_addr", imem_addr, 32'h40);
        check("mis_valid", 32'(if_id_valid), 32'h0);
        redirect = 1'b0;
        step();
        check("mis_clear", 32'(misalign), 32'h0);
        check("mis_w16", if_id_instr, 32'h1234_0010);
        // last word then halt
        redirect = 1'b1;
        redirect_target = 32'd4092;
        step();
        check("last_addr", imem_addr, 32'd4092);
        redirect = 1'b0;
        step();
        check("last_instr", if_id_instr, 32'h1234_03FF);
        check("last_pc4", if_id_pc4, 32'd4096);
        check("last_halted", 32'(halted), 32'h0);
        step();
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_valid", 32'(if_id_valid), 32'h0);
        check("halt_instr", if_id_instr, 32'h0);
        check("halt_addr", imem_addr, 32'd4096);
        redirect = 1'b1;
        redirect_target = 32'h0;
        step();
        check("halt_ign_addr", imem_addr, 32'd4096);
        check("halt_ign_flag", 32'(halted), 32'h1);
        redirect = 1'b0;
        // reset out of HALT
        reset = 1'b1;
        step();
        check_reset_values("rst_halt");
        reset = 1'b0;
        step();
        check("reboot_valid", 32'(if_id_valid), 32'h0);
        check("reboot_addr", imem_addr, 32'h0);
        step();
        check("reboot_A", if_id_instr, 32'h1234_0000);
        // reset during a stall
        stall = 1'b1;
        step();
        check("pre_rst_hold", if_id_instr, 32'h1234_0000);
        reset = 1'b1;
        step();
        check_reset_values("rst_stall");
        reset = 1'b0;
        stall = 1'b0;
        step();
        check("boot2_valid", 32'(if_id_valid), 32'h0);
        step();
        check("boot2_A", if_id_instr, 32'h1234_0000);
        check("boot2_pc4", if_id_pc4, 32'h4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
